checkbits_monitor: RTL and testbench

CHECKBITS_MONITOR -- requirements
Module: checkbits_monitor

---
 rtl/checkbits_monitor.sv | 205 ++++++++++++++++++++
 tb/tb_checkbits_monitor.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/checkbits_monitor.sv
// Purpose : arms on start, then watches a status bus step through up to DEPTH masked
//           expected values, each held STABLE_CYCLES samples; reports pass, timeout or fail-value.
// Latency : every output is registered; a qualifying sample is reflected one cycle later.
// Backpres: none; start and load_valid are ignored while armed (busy=1).
//
// Ports:
//   clock, reset                 rising-edge clock, synchronous active-high reset
//   checkbits[WIDTH]             monitored status bus
//   load_valid/index/value/mask  write one stage entry (mask bit 1 = compared)
//   seq_len, start               stage count (0 -> 1, >DEPTH -> DEPTH) and arm strobe
//   busy, pass, fail, fail_code  status; pass/fail/fail_code sticky until the next start
//   stage, elapsed               stage being awaited, saturating cycles since arm
module checkbits_monitor #(
  parameter int               WIDTH          = 16,
  parameter int               DEPTH          = 4,
  parameter int               STABLE_CYCLES  = 2,
  parameter int               TIMEOUT_CYCLES = 200000,
  parameter logic [WIDTH-1:0] FAIL_VALUE     = 16'hdead,
  parameter bit               FAIL_EN        = 1'b1
) (
  input  logic                                clock,
  input  logic                                reset,
  input  logic [WIDTH-1:0]                    checkbits,
  input  logic                                load_valid,
  input  logic [$clog2(DEPTH)-1:0]            load_index,
  input  logic [WIDTH-1:0]                    load_value,
  input  logic [WIDTH-1:0]                    load_mask,
  input  logic [$clog2(DEPTH):0]              seq_len,
  input  logic                                start,
  output logic                                busy,
  output logic                                pass,
  output logic                                fail,
  output logic [1:0]                          fail_code,
  output logic [$clog2(DEPTH):0]              stage,
  output logic [$clog2(TIMEOUT_CYCLES+1)-1:0] elapsed
);

  localparam int IW = $clog2(DEPTH);
  localparam int SW = IW + 1;
  localparam int EW = $clog2(TIMEOUT_CYCLES + 1);

  localparam logic [1:0] CODE_NONE    = 2'd0;
  localparam logic [1:0] CODE_TIMEOUT = 2'd1;
  localparam logic [1:0] CODE_FAILVAL = 2'd2;

  typedef enum logic [1:0] {S_IDLE, S_ARMED, S_PASS, S_FAIL} state_t;

  state_t           r_state;
  logic [SW-1:0]    r_stage;
  logic [SW-1:0]    r_len;
  logic [EW-1:0]    r_elapsed;
  logic [7:0]       r_cnt;
  logic             r_busy;
  logic             r_pass;
  logic             r_fail;
  logic [1:0]       r_code;
  logic [WIDTH-1:0] r_value [DEPTH];
  logic [WIDTH-1:0] r_mask  [DEPTH];

  state_t           w_state_nxt;
  logic [SW-1:0]    w_stage_nxt;
  logic [SW-1:0]    w_len_nxt;
  logic [EW-1:0]    w_elapsed_nxt;
  logic [7:0]       w_cnt_nxt;
  logic             w_busy_nxt;
  logic             w_pass_nxt;
  logic             w_fail_nxt;
  logic [1:0]       w_code_nxt;

  logic [WIDTH-1:0] w_sel_value;
  logic [WIDTH-1:0] w_sel_mask;
  logic             w_match;
  logic             w_hit_fail;
  logic             w_run_done;
  logic             w_last;
  logic             w_timeout;
  logic             w_load_ok;
  logic [SW-1:0]    w_len_clamped;

  // Out-of-range indices can only exist when DEPTH is not a power of two.
  generate
    if (DEPTH == (1 << IW)) begin : g_idx_pow2
      assign w_load_ok = 1'b1;
    end else begin : g_idx_chk
      assign w_load_ok = ({1'b0, load_index} < SW'(DEPTH));
    end
  endgenerate

  // While armed r_stage < r_len <= DEPTH, so the low bits are a valid index.
  assign w_sel_value = r_value[r_stage[IW-1:0]];
  assign w_sel_mask  = r_mask[r_stage[IW-1:0]];
  assign w_match     = ((checkbits ^ w_sel_value) & w_sel_mask) == '0;
  assign w_hit_fail  = FAIL_EN && (checkbits == FAIL_VALUE);
  // This sample is the STABLE_CYCLES-th consecutive match of the current stage.
  assign w_run_done  = w_match && (r_cnt == 8'(STABLE_CYCLES - 1));
  assign w_last      = (r_stage == r_len - SW'(1));
  assign w_timeout   = (r_elapsed == EW'(TIMEOUT_CYCLES));

  always_comb begin
    w_len_clamped = seq_len;
    if (seq_len == '0) begin
      w_len_clamped = SW'(1);
    end else if (seq_len > SW'(DEPTH)) begin
      w_len_clamped = SW'(DEPTH);
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_stage_nxt   = r_stage;
    w_len_nxt     = r_len;
    w_elapsed_nxt = r_elapsed;
    w_cnt_nxt     = r_cnt;
    w_busy_nxt    = r_busy;
    w_pass_nxt    = r_pass;
    w_fail_nxt    = r_fail;
    w_code_nxt    = r_code;
    case (r_state)
      S_ARMED: begin
        w_elapsed_nxt = w_timeout ? r_elapsed : r_elapsed + EW'(1);
        w_cnt_nxt     = w_match ? r_cnt + 8'd1 : 8'd0;
        // Priority: fail value, then final-stage completion, then timeout.
        if (w_hit_fail) begin
          w_state_nxt = S_FAIL;
          w_busy_nxt  = 1'b0;
          w_fail_nxt  = 1'b1;
          w_code_nxt  = CODE_FAILVAL;
        end else if (w_run_done && w_last) begin
          w_state_nxt = S_PASS;
          w_busy_nxt  = 1'b0;
          w_pass_nxt  = 1'b1;
          w_stage_nxt = r_stage + SW'(1);
          w_cnt_nxt   = 8'd0;
        end else if (w_timeout) begin
          w_state_nxt = S_FAIL;
          w_busy_nxt  = 1'b0;
          w_fail_nxt  = 1'b1;
          w_code_nxt  = CODE_TIMEOUT;
        end else if (w_run_done) begin
          // Each stage earns its own run, even if its masked value repeats.
          w_stage_nxt = r_stage + SW'(1);
          w_cnt_nxt   = 8'd0;
        end
      end
      default: begin
        if (start) begin
          w_state_nxt   = S_ARMED;
          w_busy_nxt    = 1'b1;
          w_stage_nxt   = '0;
          w_elapsed_nxt = '0;
          w_cnt_nxt     = 8'd0;
          w_pass_nxt    = 1'b0;
          w_fail_nxt    = 1'b0;
          w_code_nxt    = CODE_NONE;
          w_len_nxt     = w_len_clamped;
        end
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state   <= S_IDLE;
      r_stage   <= '0;
      r_len     <= SW'(1);
      r_elapsed <= '0;
      r_cnt     <= 8'd0;
      r_busy    <= 1'b0;
      r_pass    <= 1'b0;
      r_fail    <= 1'b0;
      r_code    <= CODE_NONE;
    end else begin
      r_state   <= w_state_nxt;
      r_stage   <= w_stage_nxt;
      r_len     <= w_len_nxt;
      r_elapsed <= w_elapsed_nxt;
      r_cnt     <= w_cnt_nxt;
      r_busy    <= w_busy_nxt;
      r_pass    <= w_pass_nxt;
      r_fail    <= w_fail_nxt;
      r_code    <= w_code_nxt;
    end
  end

  // Stage table: writable only while not armed, cleared by reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_value[i] <= '0;
        r_mask[i]  <= '0;
      end
    end else if (r_state != S_ARMED && load_valid && w_load_ok) begin
      r_value[load_index] <= load_value;
      r_mask[load_index]  <= load_mask;
    end
  end

  assign busy      = r_busy;
  assign pass      = r_pass;
  assign fail      = r_fail;
  assign fail_code = r_code;
  assign stage     = r_stage;
  assign elapsed   = r_elapsed;

endmodule

// File: tb/tb_checkbits_monitor.sv
`timescale 1ns/1ps
module tb_checkbits_monitor;
  localparam int SC = 2;
  localparam int TO = 100;
  localparam logic [15:0] FV = 16'hdead;
  localparam int M_IDLE = 0, M_ARMED = 1, M_PASS = 2, M_FAIL = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst = 1'b1;
  logic        load_valid = 1'b0;
  logic        start = 1'b0;
  logic [15:0] bus = 16'h0;
  logic [15:0] load_value = 16'h0;
  logic [15:0] load_mask = 16'h0;
  logic [1:0]  load_index = 2'd0;
  logic [2:0]  seq_len = 3'd0;

  logic       busy_w  [2];
  logic       pass_w  [2];
  logic       fail_w  [2];
  logic [1:0] code_w  [2];
  logic [2:0] stage_w [2];
  logic [6:0] el_w    [2];

  checkbits_monitor #(.WIDTH(16), .DEPTH(4), .STABLE_CYCLES(SC), .TIMEOUT_CYCLES(TO),
                      .FAIL_VALUE(FV), .FAIL_EN(1'b1)) dut_a (
    .clock(clk), .reset(rst), .checkbits(bus), .load_valid(load_valid),
    .load_index(load_index), .load_value(load_value), .load_mask(load_mask),
    .seq_len(seq_len), .start(start), .busy(busy_w[0]), .pass(pass_w[0]),
    .fail(fail_w[0]), .fail_code(code_w[0]), .stage(stage_w[0]), .elapsed(el_w[0]));

  checkbits_monitor #(.WIDTH(16), .DEPTH(4), .STABLE_CYCLES(SC), .TIMEOUT_CYCLES(TO),
                      .FAIL_VALUE(FV), .FAIL_EN(1'b0)) dut_b (
    .clock(clk), .reset(rst), .checkbits(bus), .load_valid(load_valid),
    .load_index(load_index), .load_value(load_value), .load_mask(load_mask),
    .seq_len(seq_len), .start(start), .busy(busy_w[1]), .pass(pass_w[1]),
    .fail(fail_w[1]), .fail_code(code_w[1]), .stage(stage_w[1]), .elapsed(el_w[1]));

  // Reference model: one entry per DUT (index 0 has fail-value detection, 1 does not).
  int          m_state [2];
  int          m_stage [2];
  int          m_el    [2];
  int          m_run   [2];
  int          m_len   [2];
  int          m_code  [2];
  int          m_pass  [2];
  int          m_fail  [2];
  logic [15:0] m_val   [2][4];
  logic [15:0] m_msk   [2][4];

  int checks = 0;
  int failures = 0;
  bit chk_on = 1'b0;

  task automatic chk(string nm, int k, int act, int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s[dut%0d] got=%0d expected=%0d at t=%0t", nm, k, act, exp, $time);
    end
  endtask

  task automatic model_step(int k, bit fe);
    bit hit;
    bit done;
    if (rst) begin
      m_state[k] = M_IDLE; m_stage[k] = 0; m_el[k] = 0; m_run[k] = 0;
      m_pass[k] = 0; m_fail[k] = 0; m_code[k] = 0;
      for (int i = 0; i < 4; i++) begin
        m_val[k][i] = 16'h0;
        m_msk[k][i] = 16'h0;
      end
    end else if (m_state[k] != M_ARMED) begin
      if (load_valid) begin
        m_val[k][load_index] = load_value;
        m_msk[k][load_index] = load_mask;
      end
      if (start) begin
        m_state[k] = M_ARMED; m_stage[k] = 0; m_el[k] = 0; m_run[k] = 0;
        m_pass[k] = 0; m_fail[k] = 0; m_code[k] = 0;
        m_len[k] = (seq_len == 3'd0) ? 1 : ((seq_len > 3'd4) ? 4 : int'(seq_len));
      end
    end else begin
      hit = (bus & m_msk[k][m_stage[k]]) == (m_val[k][m_stage[k]] & m_msk[k][m_stage[k]]);
      m_run[k] = hit ? m_run[k] + 1 : 0;
      done = (m_run[k] == SC);
      if (fe && bus == FV) begin
        m_state[k] = M_FAIL; m_fail[k] = 1; m_code[k] = 2;
      end else if (done && m_stage[k] == m_len[k] - 1) begin
        m_state[k] = M_PASS; m_pass[k] = 1; m_stage[k]++;
      end else if (m_el[k] == TO) begin
        m_state[k] = M_FAIL; m_fail[k] = 1; m_code[k] = 1;
      end else if (done) begin
        m_stage[k]++; m_run[k] = 0;
      end
      if (m_el[k] < TO) m_el[k]++;
    end
  endtask

  always @(posedge clk) begin
    model_step(0, 1'b1);
    model_step(1, 1'b0);
  end

  always @(negedge clk) begin
    if (chk_on) begin
      for (int k = 0; k < 2; k++) begin
        chk("busy",    k, int'(busy_w[k]),  (m_state[k] == M_ARMED) ? 1 : 0);
        chk("pass",    k, int'(pass_w[k]),  m_pass[k]);
        chk("fail",    k, int'(fail_w[k]),  m_fail[k]);
        chk("code",    k, int'(code_w[k]),  m_code[k]);
        chk("stage",   k, int'(stage_w[k]), m_stage[k]);
        chk("elapsed", k, int'(el_w[k]),    m_el[k]);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_load(int i, logic [15:0] v, logic [15:0] m);
    load_valid = 1'b1; load_index = 2'(i); load_value = v; load_mask = m;
    tick();
    load_valid = 1'b0;
  endtask

  task automatic arm(int n);
    seq_len = 3'(n); start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic drive(logic [15:0] v, int n);
    bus = v;
    repeat (n) tick();
  endtask

  function automatic logic [15:0] rand_mask();
    case ($urandom_range(0, 3))
      0:       return 16'hffff;
      1:       return 16'h00ff;
      2:       return 16'h0000;
      default: return 16'($urandom);
    endcase
  endfunction

  initial begin
    int r;
    int st;
    int n;
    int nl;
    rst = 1'b1;
    tick();
    chk_on = 1'b1;
    tick();
    rst = 1'b0;
    chk("rst_busy", 0, int'(busy_w[0]), 0);
    chk("rst_pass", 0, int'(pass_w[0]), 0);
    chk("rst_fail", 0, int'(fail_w[0]), 0);
    chk("rst_code", 0, int'(code_w[0]), 0);
    chk("rst_stage", 0, int'(stage_w[0]), 0);
    chk("rst_elapsed", 0, int'(el_w[0]), 0);

    // Single stage, two matching samples.
    do_load(0, 16'h00d5, 16'hffff);
    arm(1);
    chk("t1_armed_busy", 0, int'(busy_w[0]), 1);
    drive(16'h00d5, 1);
    chk("t1_pass_early", 0, int'(pass_w[0]), 0);
    drive(16'h00d5, 1);
    chk("t1_pass", 0, int'(pass_w[0]), 1);
    chk("t1_stage", 0, int'(stage_w[0]), 1);
    chk("t1_busy", 0, int'(busy_w[0]), 0);
    chk("t1_elapsed", 0, int'(el_w[0]), 2);
    chk("t1_model_pass", 0, m_pass[0], 1);

    // Three stages with a glitch in the middle one.
    do_load(0, 16'h0001, 16'hffff);
    do_load(1, 16'h0002, 16'hffff);
    do_load(2, 16'h0003, 16'hffff);
    arm(3);
    drive(16'h0001, 2);
    chk("t2_stage1", 0, int'(stage_w[0]), 1);
    drive(16'h0002, 1);
    drive(16'h0000, 1);
    chk("t2_glitch_hold", 0, int'(stage_w[0]), 1);
    drive(16'h0002, 1);
    chk("t2_restart_hold", 0, int'(stage_w[0]), 1);
    drive(16'h0002, 1);
    chk("t2_stage2", 0, int'(stage_w[0]), 2);
    drive(16'h0003, 2);
    chk("t2_pass", 0, int'(pass_w[0]), 1);
    chk("t2_stage3", 0, int'(stage_w[0]), 3);

    // Timeout with no match.
    do_load(0, 16'h1234, 16'hffff);
    arm(1);
    drive(16'h0000, 100);
    chk("t3_still_busy", 0, int'(busy_w[0]), 1);
    chk("t3_el_sat", 0, int'(el_w[0]), 100);
    drive(16'h0000, 1);
    chk("t3_fail", 0, int'(fail_w[0]), 1);
    chk("t3_code", 0, int'(code_w[0]), 1);
    chk("t3_elapsed", 0, int'(el_w[0]), 100);
    chk("t3_model_code", 0, m_code[0], 1);

    // Final match completing exactly at the timeout boundary.
    do_load(0, 16'h0042, 16'hffff);
    arm(1);
    drive(16'h0000, 99);
    drive(16'h0042, 1);
    chk("t4_busy", 0, int'(busy_w[0]), 1);
    drive(16'h0042, 1);
    chk("t4_pass", 0, int'(pass_w[0]), 1);
    chk("t4_fail", 0, int'(fail_w[0]), 0);
    chk("t4_elapsed", 0, int'(el_w[0]), 100);

    // Fail value at stage 1; the FAIL_EN=0 instance carries on and passes.
    do_load(0, 16'h0011, 16'hffff);
    do_load(1, 16'h0022, 16'hffff);
    arm(2);
    drive(16'h0011, 2);
    chk("t5_stage", 0, int'(stage_w[0]), 1);
    drive(16'hdead, 1);
    chk("t5_fail", 0, int'(fail_w[0]), 1);
    chk("t5_code", 0, int'(code_w[0]), 2);
    chk("t5_stage_hold", 0, int'(stage_w[0]), 1);
    chk("t5_nofail_busy", 1, int'(busy_w[1]), 1);
    chk("t5_nofail_fail", 1, int'(fail_w[1]), 0);
    drive(16'h0022, 2);
    chk("t5_nofail_pass", 1, int'(pass_w[1]), 1);
    chk("t5_sticky_code", 0, int'(code_w[0]), 2);
    chk("t5_sticky_stage", 0, int'(stage_w[0]), 1);

    // Reset mid-run at stage 2, with start and a load in the same cycle.
    do_load(0, 16'h0001, 16'hffff);
    do_load(1, 16'h0002, 16'hffff);
    do_load(2, 16'h0003, 16'hffff);
    arm(3);
    drive(16'h0001, 2);
    drive(16'h0002, 2);
    chk("t6_stage2", 0, int'(stage_w[0]), 2);
    rst = 1'b1; start = 1'b1; seq_len = 3'd3;
    load_valid = 1'b1; load_index = 2'd0; load_value = 16'h5555; load_mask = 16'hffff;
    tick();
    rst = 1'b0; start = 1'b0; load_valid = 1'b0;
    for (int k = 0; k < 2; k++) begin
      chk("t6_busy", k, int'(busy_w[k]), 0);
      chk("t6_stage", k, int'(stage_w[k]), 0);
      chk("t6_elapsed", k, int'(el_w[k]), 0);
      chk("t6_pass", k, int'(pass_w[k]), 0);
    end
    arm(3);
    for (int c = 0; c < 5; c++) drive(16'($urandom_range(0, 16'hdd00)), 1);
    chk("t6_pass_early", 0, int'(pass_w[0]), 0);
    drive(16'($urandom_range(0, 16'hdd00)), 1);
    chk("t6_pass", 0, int'(pass_w[0]), 1);
    chk("t6_stage3", 0, int'(stage_w[0]), 3);

    // Randomized episodes, checked cycle by cycle against the model.
    for (int ep = 0; ep < 50; ep++) begin
      nl = $urandom_range(0, 4);
      for (int j = 0; j < nl; j++) do_load($urandom_range(0, 3), 16'($urandom), rand_mask());
      arm($urandom_range(0, 7));
      n = $urandom_range(5, 130);
      for (int c = 0; c < n; c++) begin
        r = $urandom_range(0, 99);
        st = m_stage[0] % 4;
        if (r < 60)      bus = (m_val[0][st] & m_msk[0][st]) | (16'($urandom) & ~m_msk[0][st]);
        else if (r < 63) bus = FV;
        else if (r < 90) bus = 16'($urandom);
        start      = ($urandom_range(0, 19) == 0);
        seq_len    = 3'($urandom_range(0, 7));
        load_valid = ($urandom_range(0, 19) == 0);
        load_index = 2'($urandom_range(0, 3));
        load_value = 16'($urandom);
        load_mask  = rand_mask();
        rst        = ($urandom_range(0, 199) == 0);
        tick();
      end
      start = 1'b0; load_valid = 1'b0; rst = 1'b0;
    end

    @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
